// File: rtl/axi_arb_pkg.sv
// ============================================================================
//  Module      : axi_arb_pkg
//  Description : Shared types and constants for the AXI control-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axi_arb_pkg

`default_nettype wire

// File: rtl/axi_ctrl_arbiter_if.sv
// ============================================================================
//  Module      : axi_ctrl_arbiter_if
//  Description : Requester-side and master-side signal bundle of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_ctrl_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]          req_wstrb;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [1:0]                    rsp_resp;

    // Master side
    logic                          m_start;
    logic                          m_write;
    logic [ADDR_WIDTH-1:0]         m_addr;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic [3:0]                    m_wstrb;
    logic                          m_busy;
    logic                          m_done;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic [1:0]                    m_resp;

    // Status
    logic                          timeout_err;
    logic                          stray_done;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  m_busy, m_done, m_rdata, m_resp,
        output req_ready, req_done, rsp_rdata, rsp_resp,
        output m_start, m_write, m_addr, m_wdata, m_wstrb,
        output timeout_err, stray_done
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output m_busy, m_done, m_rdata, m_resp,
        input  req_ready, req_done, rsp_rdata, rsp_resp,
        input  m_start, m_write, m_addr, m_wdata, m_wstrb,
        input  timeout_err, stray_done
    );

endinterface : axi_ctrl_arbiter_if

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational one-hot round-robin picker; searches from ptr+1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0]            w_above;
    logic [N-1:0]            w_req_hi;
    logic [N-1:0]            w_pick_src;
    logic [IDX_W-1:0][N-1:0] w_idx_bits;

    for (genvar i = 0; i < N; i++) begin : g_above
        assign w_above[i] = (IDX_W'(i) > ptr_i);
    end

    // Prefer requesters above the pointer; wrap to the full vector otherwise.
    assign w_req_hi   = req_i & w_above;
    assign w_pick_src = (|w_req_hi) ? w_req_hi : req_i;
    assign gnt_o      = w_pick_src & (~w_pick_src + N'(1));

    for (genvar b = 0; b < IDX_W; b++) begin : g_enc_bit
        for (genvar i = 0; i < N; i++) begin : g_enc_req
            localparam bit SEL = (((i >> b) & 1) != 0);
            assign w_idx_bits[b][i] = gnt_o[i] & SEL;
        end
        assign idx_o[b] = |w_idx_bits[b];
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/axi_ctrl_arbiter.sv
// ============================================================================
//  Module      : axi_ctrl_arbiter
//  Description : Round-robin sharing of one AXI4-Lite control master among
//                NUM_REQ requesters, one transaction in flight, with watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_ctrl_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_ctrl_arbiter_if.slave  bus
);

    localparam int  IDX_W   = $clog2(NUM_REQ);
    localparam int  CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit  WD_EN   = (TIMEOUT_CYC != 0);
    localparam int  TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    stray_q, stray_d;

    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_grant;
    logic                    w_expire;
    logic [NUM_REQ-1:0]      w_owner_oh;
    logic                    w_start;
    logic [NUM_REQ-1:0]      w_ready;
    logic [NUM_REQ-1:0]      w_done;

    logic [ADDR_WIDTH-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [NUM_REQ];
    logic [3:0]              w_wstrb_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_addr_arr[k]  = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[k] = bus.req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_wstrb_arr[k] = bus.req_wstrb[k*4 +: 4];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt_oh),
        .idx_o (w_gnt_idx)
    );

    // The busy guard also covers a master still finishing a timed-out transfer.
    assign w_grant    = (state_q == ST_IDLE) && (|w_gnt_oh) && !bus.m_busy;
    assign w_expire   = WD_EN && (cnt_q == TO_LAST_C);
    assign w_owner_oh = NUM_REQ'(1) << owner_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_grant) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.m_done || w_expire) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_ready = '0;
        w_done  = '0;
        case (state_q)
            ST_ISSUE: begin
                w_start = 1'b1;
                w_ready = w_owner_oh;
            end
            ST_RESP:  w_done = w_owner_oh;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        stray_d   = stray_q;

        if (w_grant) begin
            owner_d = w_gnt_idx;
            write_d = bus.req_write[w_gnt_idx];
            addr_d  = w_addr_arr[w_gnt_idx];
            wdata_d = w_wdata_arr[w_gnt_idx];
            wstrb_d = w_wstrb_arr[w_gnt_idx];
        end

        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end

        // A real completion takes priority over a simultaneous expiry.
        if (state_q == ST_WAIT) begin
            if (bus.m_done) begin
                rdata_d = bus.m_rdata;
                resp_d  = bus.m_resp;
            end else if (w_expire) begin
                rdata_d   = '0;
                resp_d    = RESP_SLVERR;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_q == ST_RESP) begin
            ptr_d = owner_q;
        end

        if (bus.m_done && (state_q != ST_WAIT)) begin
            stray_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            stray_q   <= stray_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.m_start     = w_start;
    assign bus.req_ready   = w_ready;
    assign bus.req_done    = w_done;
    assign bus.m_write     = write_q;
    assign bus.m_addr      = addr_q;
    assign bus.m_wdata     = wdata_q;
    assign bus.m_wstrb     = wstrb_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_resp    = resp_q;
    assign bus.timeout_err = timeout_q;
    assign bus.stray_done  = stray_q;

endmodule : axi_ctrl_arbiter

`default_nettype wire
